// File: rtl/button_conditioner.sv
// Turns raw, bouncing push-button pins into clean clk-domain events.
// Each channel: 2-FF synchroniser, debounce FSM, press/release pulses, level, auto-repeat.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 0,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned REP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W     = (REP_MAX < 1) ? 1 : $clog2(REP_MAX + 1);
  localparam bit          REPEAT_ON = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHK_PRESS = 2'd1,
    HELD      = 2'd2,
    CHK_REL   = 2'd3
  } state_e;

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;

  // Polarity is normalised before the synchroniser so everything downstream is active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw ^ {NUM_BTN{ACTIVE_LOW}};
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               rep_first_q, rep_first_d;
    logic               press_q, press_d;
    logic               rel_q, rel_d;
    logic               lvl_q, lvl_d;
    logic               cnt_done;
    logic               rep_done;
    int unsigned        rep_target;

    // cnt holds the stable samples already seen; the current sample completes the run.
    assign cnt_done   = (32'(cnt_q) + 32'd1) >= DEBOUNCE_CYCLES;
    assign rep_target = rep_first_q ? REPEAT_DELAY : REPEAT_PERIOD;
    assign rep_done   = (32'(rep_q) + 32'd1) >= rep_target;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        rep_q       <= '0;
        rep_first_q <= 1'b1;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        lvl_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        rep_q       <= rep_d;
        rep_first_q <= rep_first_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        lvl_q       <= lvl_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      lvl_d       = lvl_q;
      unique case (state_q)
        IDLE: begin
          if (s2[i]) begin
            if (cnt_done) begin
              state_d     = HELD;
              cnt_d       = '0;
              lvl_d       = 1'b1;
              press_d     = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b1;
            end else begin
              state_d = CHK_PRESS;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHK_PRESS: begin
          if (!s2[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d     = HELD;
            cnt_d       = '0;
            lvl_d       = 1'b1;
            press_d     = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2[i]) begin
            if (cnt_done) begin
              state_d = IDLE;
              cnt_d   = '0;
              lvl_d   = 1'b0;
              rel_d   = 1'b1;
            end else begin
              state_d = CHK_REL;
              cnt_d   = CNT_W'(1);
            end
          end else if (REPEAT_ON) begin
            // Restarting rep on each pulse keeps it bounded by its target, so it never wraps.
            if (rep_done) begin
              press_d     = 1'b1;
              rep_d       = '0;
              rep_first_d = 1'b0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end
        end
        CHK_REL: begin
          if (s2[i]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_done) begin
            state_d = IDLE;
            cnt_d   = '0;
            lvl_d   = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_level[i]   = lvl_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulse events are queued as stimulus is driven, then matched on output.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a_raw = 2'b00;
  logic [1:0] b_raw = 2'b11;
  logic [1:0] a_press, a_rel, a_level;
  logic [1:0] b_press, b_rel, b_level;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_q[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Active-high, repeat off
  button_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(0), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_raw(a_raw),
    .btn_press(a_press), .btn_release(a_rel), .btn_level(a_level)
  );

  // Active-low, repeat 8/3
  button_conditioner #(
    .NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_raw(b_raw),
    .btn_press(b_press), .btn_release(b_rel), .btn_level(b_level)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Event code: cycle in upper bits, then dut, channel, kind (0 press, 1 release)
  function automatic int unsigned ev_code(input int unsigned c, input int unsigned d,
                                          input int unsigned ch, input int unsigned k);
    return (c << 4) | (d << 2) | (ch << 1) | k;
  endfunction

  task automatic pop_cmp(input int unsigned code);
    if (exp_q.size() == 0) check_eq("unexpected_evt", code, 0);
    else check_eq("evt", code, exp_q.pop_front());
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    logic pr, rl;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < 2; ch++) begin
          pr = (d == 0) ? a_press[ch] : b_press[ch];
          rl = (d == 0) ? a_rel[ch]   : b_rel[ch];
          if (pr && rl) check_eq("press_rel_excl", 1, 0);
          if (pr) pop_cmp(ev_code(cyc, 32'(d), 32'(ch), 0));
          if (rl) pop_cmp(ev_code(cyc, 32'(d), 32'(ch), 1));
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    run_to(2);
    check_eq("rst_a_press", 32'(a_press), 0);
    check_eq("rst_a_rel",   32'(a_rel),   0);
    check_eq("rst_a_level", 32'(a_level), 0);
    check_eq("rst_b_press", 32'(b_press), 0);
    check_eq("rst_b_rel",   32'(b_rel),   0);
    check_eq("rst_b_level", 32'(b_level), 0);
    mon_en = 1'b1;
    run_to(3);
    rst = 1'b0;

    // Clean press: first sampling edge 10 -> pulse after edge 15
    run_to(9);
    a_raw[0] = 1'b1;
    exp_q.push_back(ev_code(15, 0, 0, 0));
    run_to(14);
    check_eq("clean_level_pre", 32'(a_level[0]), 0);
    run_to(15);
    check_eq("clean_level", 32'(a_level[0]), 1);

    // Release: first sampling edge 40 -> pulse after edge 45
    run_to(39);
    a_raw[0] = 1'b0;
    exp_q.push_back(ev_code(45, 0, 0, 1));
    run_to(44);
    check_eq("rel_level_pre", 32'(a_level[0]), 1);
    run_to(45);
    check_eq("rel_level", 32'(a_level[0]), 0);

    // Bounce 1,1,0 then stable 1: timed from the last rising edge
    run_to(50);
    a_raw[1] = 1'b1;
    run_to(52);
    a_raw[1] = 1'b0;
    run_to(53);
    a_raw[1] = 1'b1;
    exp_q.push_back(ev_code(59, 0, 1, 0));
    run_to(58);
    check_eq("bounce_level_pre", 32'(a_level[1]), 0);
    run_to(59);
    check_eq("bounce_level", 32'(a_level[1]), 1);
    run_to(65);
    a_raw[1] = 1'b0;
    exp_q.push_back(ev_code(71, 0, 1, 1));

    // Reset during debounce, then during HELD; held button re-presses after a full debounce
    run_to(80);
    a_raw[0] = 1'b1;
    run_to(84);
    rst = 1'b1;
    run_to(85);
    check_eq("rst_chk_out", 32'({a_press, a_rel, a_level}), 0);
    run_to(86);
    rst = 1'b0;
    exp_q.push_back(ev_code(92, 0, 0, 0));
    run_to(92);
    check_eq("rst_repress_level", 32'(a_level[0]), 1);
    run_to(95);
    rst = 1'b1;
    run_to(96);
    check_eq("rst_held_out", 32'({a_press, a_rel, a_level}), 0);
    run_to(97);
    rst = 1'b0;
    exp_q.push_back(ev_code(103, 0, 0, 0));
    run_to(106);
    a_raw[0] = 1'b0;
    exp_q.push_back(ev_code(112, 0, 0, 1));

    // Auto-repeat: press at 126, repeats at +8 then every 3 while held (held until 152)
    run_to(120);
    b_raw[0] = 1'b0;
    exp_q.push_back(ev_code(126, 1, 0, 0));
    for (int t = 134; t <= 152; t += 3) exp_q.push_back(ev_code(32'(t), 1, 0, 0));
    exp_q.push_back(ev_code(156, 1, 0, 1));
    run_to(130);
    check_eq("rep_level", 32'(b_level[0]), 1);
    run_to(150);
    b_raw[0] = 1'b1;
    run_to(160);
    check_eq("rep_level_after", 32'(b_level[0]), 0);

    // Both active-low channels pressed together
    run_to(170);
    b_raw = 2'b00;
    exp_q.push_back(ev_code(176, 1, 0, 0));
    exp_q.push_back(ev_code(176, 1, 1, 0));
    run_to(176);
    check_eq("dual_level", 32'(b_level), 3);
    run_to(178);
    b_raw = 2'b11;
    exp_q.push_back(ev_code(184, 1, 0, 1));
    exp_q.push_back(ev_code(184, 1, 1, 1));

    run_to(200);
    check_eq("drain", exp_q.size(), 0);
    check_eq("final_levels", 32'({a_level, b_level}), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
